// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, round-robin on ties.
// Latency: accept in cycle T, response valid in T+2, at least 3 cycles per op.
// Backpressure: the response is held until the owner's ready; no new accept until then.
// Optional grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [3:0]        req0_aluop,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [3:0]        req1_aluop,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_aluop,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nx;
  logic              gnt_any;      // some requester is valid
  logic              gnt;          // requester that would win this cycle
  logic              last_grant;   // requester accepted most recently
  logic              owner;        // requester of the in-flight operation
  logic              accept;
  logic [DATA_W-1:0] op1_q, op2_q, res_q;
  logic [3:0]        aluop_q;
  logic              zero_q;

  // Pick the winner: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt     = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt = ~last_grant;
    end else if (req1_valid) begin
      gnt = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          req0_ready = ~gnt;
          req1_ready = gnt;
          state_nx   = EXEC;
        end
      end
      EXEC: begin
        state_nx = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign accept = req0_ready | req1_ready;

  // Operand capture on accept, result capture while the ALU is driven in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q      <= '0;
      op2_q      <= '0;
      aluop_q    <= 4'b0000;
      res_q      <= '0;
      zero_q     <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        op1_q      <= gnt ? req1_op1   : req0_op1;
        op2_q      <= gnt ? req1_op2   : req0_op2;
        aluop_q    <= gnt ? req1_aluop : req0_aluop;
        owner      <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_aluop   = aluop_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign busy        = (state != IDLE);

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester accept counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != {CNT_W{1'b1}})) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (req1_ready && (grant_cnt1 != {CNT_W{1'b1}})) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule
